// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result bundle for the pipelined carry-lookahead adder/subtractor.
// The slave side is the adder; the master side is the producer/consumer.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry, overflow, zero
    );

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready flow control.
// S1 registers operands and 4-bit group P/G; S2 resolves carries and flags.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_cla_addsub_if.slave  bus
);
    localparam int NG = WIDTH / 4;

    if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
        $error("pipelined_cla_addsub: WIDTH must be a multiple of 4 and at least 8");
    end

    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_accept;

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NG-1:0]    w_gp;
    logic [NG-1:0]    w_gg;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_bx;
    logic             r_cin;
    // Bit 3 of each group only feeds the group P/G, so only bits 0..2 are kept.
    logic [NG-1:0][2:0] r_p;
    logic [NG-1:0][2:0] r_g;
    logic [NG-1:0]    r_gp;
    logic [NG-1:0]    r_gg;

    logic [NG:0]      w_gc;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;

    assign w_s2_free = !r_out_valid || bus.out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign w_accept  = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !r_s1_valid || w_s2_free;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;

    always_comb begin
        w_gp = '0;
        w_gg = '0;
        w_bx = bus.b ^ {WIDTH{bus.sub}};
        w_p  = bus.a | w_bx;
        w_g  = bus.a & w_bx;
        for (int k = 0; k < NG; k++) begin
            w_gp[k] = &w_p[4*k +: 4];
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_bx       <= '0;
            r_cin      <= 1'b0;
            r_p        <= '0;
            r_g        <= '0;
            r_gp       <= '0;
            r_gg       <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_accept) begin
                r_a   <= bus.a;
                r_bx  <= w_bx;
                r_cin <= bus.sub;
                r_gp  <= w_gp;
                r_gg  <= w_gg;
                for (int k = 0; k < NG; k++) begin
                    r_p[k] <= w_p[4*k +: 3];
                    r_g[k] <= w_g[4*k +: 3];
                end
            end
        end
    end

    // Second lookahead level over groups, then 4-bit lookahead inside each group.
    always_comb begin
        w_gc    = '0;
        w_c     = '0;
        w_gc[0] = r_cin;
        for (int k = 0; k < NG; k++) begin
            w_gc[k+1] = r_gg[k] | (r_gp[k] & w_gc[k]);
        end
        for (int k = 0; k < NG; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = r_g[k][0] | (r_p[k][0] & w_gc[k]);
            w_c[4*k+2] = r_g[k][1]
                       | (r_p[k][1] & r_g[k][0])
                       | (r_p[k][1] & r_p[k][0] & w_gc[k]);
            w_c[4*k+3] = r_g[k][2]
                       | (r_p[k][2] & r_g[k][1])
                       | (r_p[k][2] & r_p[k][1] & r_g[k][0])
                       | (r_p[k][2] & r_p[k][1] & r_p[k][0] & w_gc[k]);
        end
        w_c[WIDTH] = w_gc[NG];
        w_sum      = r_a ^ r_bx ^ w_c[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_sum       <= w_sum;
            r_carry     <= w_c[WIDTH];
            r_overflow  <= w_c[WIDTH] ^ w_c[WIDTH-1];
            r_zero      <= ~|w_sum;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: 32-bit and 8-bit instances checked against
// an arithmetic reference with a FIFO scoreboard and directed known answers.
module tb_pipelined_cla_addsub;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_cla_addsub_if #(.WIDTH(32)) b32 ();
    pipelined_cla_addsub_if #(.WIDTH(8))  b8 ();

    pipelined_cla_addsub #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    pipelined_cla_addsub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        ov;
        logic        z;
        int          t;
    } exp_t;

    typedef struct {
        logic        iv;
        logic        ir;
        logic        ovld;
        logic        ordy;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        c;
        logic        ovf;
        logic        z;
    } samp_t;

    exp_t fifo [2][64];
    int   head [2];
    int   tail [2];
    logic acc  [2];
    bit   pend [2];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc_no = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s w%0d: observed %0h expected %0h", tag, (d == 0) ? 32 : 8, obs, expv);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub, input int w);
        exp_t   e;
        longint m, ua, ub, sa, sb, r, u;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        r  = sub ? sa - sb : sa + sb;
        u  = sub ? ua - ub : ua + ub;
        if (u < 0) u = u + m;
        u    = u % m;
        e.sum = 32'(u);
        e.c   = sub ? (ua >= ub) : ((ua + ub) >= m);
        e.ov  = (r >= m / 2) || (r < -(m / 2));
        e.z   = (u == 0);
        e.t   = 0;
        return e;
    endfunction

    function automatic samp_t grab(input int d);
        samp_t s;
        if (d == 0) begin
            s.iv = b32.in_valid;  s.ir = b32.in_ready;  s.ovld = b32.out_valid; s.ordy = b32.out_ready;
            s.a  = b32.a;         s.b  = b32.b;         s.sub  = b32.sub;
            s.sum = b32.sum;      s.c  = b32.carry;     s.ovf  = b32.overflow;  s.z = b32.zero;
        end else begin
            s.iv = b8.in_valid;   s.ir = b8.in_ready;   s.ovld = b8.out_valid;  s.ordy = b8.out_ready;
            s.a  = {24'h0, b8.a}; s.b  = {24'h0, b8.b}; s.sub  = b8.sub;
            s.sum = {24'h0, b8.sum}; s.c = b8.carry;    s.ovf  = b8.overflow;   s.z = b8.zero;
        end
        return s;
    endfunction

    // Occupancy-level expectations: ready unless two beats pending and stalled;
    // the oldest beat is visible exactly two handshake samples after acceptance.
    task automatic score(input int d, input samp_t s);
        int   n;
        logic eir, eov;
        exp_t e;
        n   = tail[d] - head[d];
        eir = (n < 2) || s.ordy;
        chk("in_ready", d, 32'(s.ir), 32'(eir));
        eov = 1'b0;
        if (n > 0) begin
            e   = fifo[d][head[d] % 64];
            eov = (cyc_no - e.t) >= 2;
        end
        chk("out_valid", d, 32'(s.ovld), 32'(eov));
        if (eov) begin
            chk("sum", d, s.sum, e.sum);
            chk("carry", d, 32'(s.c), 32'(e.c));
            chk("overflow", d, 32'(s.ovf), 32'(e.ov));
            chk("zero", d, 32'(s.z), 32'(e.z));
            if (s.ordy) head[d]++;
        end
        acc[d] = s.iv && s.ir;
        if (acc[d]) begin
            e   = model(s.a, s.b, s.sub, (d == 0) ? 32 : 8);
            e.t = cyc_no;
            fifo[d][tail[d] % 64] = e;
            tail[d]++;
        end
    endtask

    task automatic cyc();
        samp_t s0, s1;
        @(negedge clk);
        s0 = grab(0);
        s1 = grab(1);
        score(0, s0);
        score(1, s1);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic iv, input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (d == 0) begin
            b32.in_valid = iv; b32.a = a; b32.b = b; b32.sub = sub;
        end else begin
            b8.in_valid = iv; b8.a = a[7:0]; b8.b = b[7:0]; b8.sub = sub;
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int k;
        drive(0, 1'b1, a, b, sub);
        k = 0;
        do begin
            cyc();
            k++;
        end while (!acc[0] && k < 10);
        chk("accept", 0, 32'(acc[0]), 32'd1);
        b32.in_valid = 1'b0;
    endtask

    task automatic kat(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] es, input logic ec, input logic eo, input logic ez);
        bit seen;
        b32.out_ready = 1'b1;
        push_beat(a, b, sub);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            cyc();
            if (b32.out_valid === 1'b1) begin
                seen = 1'b1;
                chk("kat_sum", 0, b32.sum, es);
                chk("kat_carry", 0, 32'(b32.carry), 32'(ec));
                chk("kat_overflow", 0, 32'(b32.overflow), 32'(eo));
                chk("kat_zero", 0, 32'(b32.zero), 32'(ez));
            end
        end
        chk("kat_result_seen", 0, 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] rnd(input int d);
        logic [31:0] v;
        logic [31:0] mask;
        mask = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = mask;
            2:       v = (mask >> 1) + 32'd1;
            3:       v = mask >> 1;
            default: v = $urandom;
        endcase
        return v & mask;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bi;
        for (int d = 0; d < 2; d++) begin
            head[d] = 0; tail[d] = 0; acc[d] = 1'b0; pend[d] = 1'b0;
            drive(d, 1'b0, 32'h0, 32'h0, 1'b0);
        end
        b32.out_ready = 1'b1;
        b8.out_ready  = 1'b1;
        rst = 1'b1;
        repeat (2) cyc();
        chk("rst_out_valid", 0, 32'(b32.out_valid), 32'd0);
        chk("rst_sum", 0, b32.sum, 32'd0);
        chk("rst_carry", 0, 32'(b32.carry), 32'd0);
        chk("rst_overflow", 0, 32'(b32.overflow), 32'd0);
        chk("rst_zero", 0, 32'(b32.zero), 32'd0);
        chk("rst_in_ready", 0, 32'(b32.in_ready), 32'd1);
        chk("rst_out_valid", 1, 32'(b8.out_valid), 32'd0);
        rst = 1'b0;
        cyc();

        kat(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        kat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        kat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        kat(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        kat(32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        kat(32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        kat(32'h1234_5678, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);

        // Four back-to-back beats with the consumer stalled for the first three result cycles.
        b32.in_valid = 1'b0;
        repeat (3) cyc();
        bi = 0;
        for (int c = 0; c < 14; c++) begin
            b32.out_ready = !(c >= 2 && c < 5);
            if (bi < 4) drive(0, 1'b1, 32'(bi + 1), 32'(bi + 1), 1'b0);
            else        b32.in_valid = 1'b0;
            cyc();
            if (acc[0]) bi++;
            if (c >= 2 && c < 5) begin
                chk("stall_sum", 0, b32.sum, 32'd2);
                chk("stall_in_ready", 0, 32'(b32.in_ready), 32'd0);
            end
        end
        chk("stream_accepted", 0, 32'(bi), 32'd4);
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        repeat (4) cyc();
        chk("stream_drained", 0, 32'(tail[0] - head[0]), 32'd0);

        // Asynchronous reset with both stages occupied.
        b32.out_ready = 1'b0;
        push_beat(32'd10, 32'd20, 1'b0);
        push_beat(32'd30, 32'd40, 1'b1);
        chk("pre_rst_out_valid", 0, 32'(b32.out_valid), 32'd1);
        chk("pre_rst_in_ready", 0, 32'(b32.in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 0, 32'(b32.out_valid), 32'd0);
        chk("async_rst_in_ready", 0, 32'(b32.in_ready), 32'd1);
        chk("async_rst_sum", 0, b32.sum, 32'd0);
        for (int d = 0; d < 2; d++) head[d] = tail[d];
        cyc();
        rst = 1'b0;
        b32.out_ready = 1'b1;
        cyc();
        kat(32'h0000_0009, 32'h0000_0004, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b0);

        // Random traffic on both widths with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!pend[d]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        drive(d, 1'b1, rnd(d), rnd(d), 1'($urandom_range(0, 1)));
                        pend[d] = 1'b1;
                    end else begin
                        drive(d, 1'b0, 32'h0, 32'h0, 1'b0);
                    end
                end
            end
            b32.out_ready = ($urandom_range(0, 3) != 0);
            b8.out_ready  = ($urandom_range(0, 3) != 0);
            cyc();
            for (int d = 0; d < 2; d++) if (acc[d]) pend[d] = 1'b0;
        end
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 32'h0, 32'h0, 1'b0);
        b32.out_ready = 1'b1;
        b8.out_ready  = 1'b1;
        repeat (6) cyc();
        chk("final_drained", 0, 32'(tail[0] - head[0]), 32'd0);
        chk("final_drained", 1, 32'(tail[1] - head[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
